// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - control and status bundle for the program-counter / return-stack unit
//
// master : drives pc_en, op, cond, pc_in, disp, clr_err; observes the status outputs
// slave  : the pc_stack_unit side; drives pc_out, sp, stack_empty, stack_full,
//          overflow, underflow
//
// op encoding: 0 INC, 1 LOAD, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6-7 reserved (hold)
interface pc_stack_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DISP_W = 8,
  parameter int DEPTH  = 8
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  logic              pc_en;
  logic [2:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] pc_in;
  logic [DISP_W-1:0] disp;
  logic              clr_err;

  logic [ADDR_W-1:0] pc_out;
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output pc_en, op, cond, pc_in, disp, clr_err,
    input  pc_out, sp, stack_empty, stack_full, overflow, underflow
  );

  modport slave (
    input  pc_en, op, cond, pc_in, disp, clr_err,
    output pc_out, sp, stack_empty, stack_full, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with branch/call/return and a LIFO return-address stack
//
// clk   : single clock, all state updates on the rising edge
// reset : synchronous active-high; pc_out=RESET_ADDR, sp=0, error flags cleared
// bus   : pc_stack_unit_if.slave
//   pc_en       advance enable; when low only clr_err has an effect
//   op          0 INC, 1 LOAD, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6-7 hold
//   cond        branch taken when high (BRANCH only)
//   pc_in       absolute target for LOAD and CALL
//   disp        signed displacement for BRANCH
//   clr_err     clears sticky overflow/underflow (a same-cycle set wins)
//   pc_out      registered program counter
//   sp          registered number of valid stack entries, 0..DEPTH
//   stack_empty sp == 0
//   stack_full  sp == DEPTH
//   overflow    sticky, CALL attempted while full
//   underflow   sticky, RET attempted while empty
//
// DISP_W must be <= ADDR_W; DEPTH must be a power of two >= 2.
module pc_stack_unit #(
  parameter int                       ADDR_W     = 10,
  parameter int                       DISP_W     = 8,
  parameter int                       DEPTH      = 8,
  parameter logic [ADDR_W-1:0]        RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  pc_stack_unit_if.slave    bus
);
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } op_t;

  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q;
  logic              overflow_q;
  logic              underflow_q;

  // Return addresses; entries at or above sp are stale and never read.
  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [ADDR_W-1:0] disp_ext;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              is_full;
  logic              is_empty;

  // Sign-extend through a signed cast so DISP_W == ADDR_W needs no special case.
  assign disp_ext  = ADDR_W'($signed(bus.disp));
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign pc_branch = pc_q + disp_ext;

  // sp is one bit wider than the index; the low bits address the next free slot.
  assign push_idx  = sp_q[IDX_W-1:0];
  assign top_idx   = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign is_full   = (sp_q == SP_W'(DEPTH));
  assign is_empty  = (sp_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_ADDR;
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Clear first so that an error raised below in the same cycle takes priority.
      if (bus.clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (bus.pc_en) begin
        case (op_t'(bus.op))
          OP_INC:    pc_q <= pc_inc;
          OP_LOAD:   pc_q <= bus.pc_in;
          OP_BRANCH: pc_q <= bus.cond ? pc_branch : pc_inc;
          OP_CALL: begin
            if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              stack_mem[push_idx] <= pc_inc;
              sp_q                <= sp_q + SP_W'(1);
              pc_q                <= bus.pc_in;
            end
          end
          OP_RET: begin
            if (is_empty) begin
              underflow_q <= 1'b1;
            end else begin
              pc_q <= stack_mem[top_idx];
              sp_q <= sp_q - SP_W'(1);
            end
          end
          default: pc_q <= pc_q;
        endcase
      end
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_empty = is_empty;
  assign bus.stack_full  = is_full;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - self-checking bench for pc_stack_unit against a queue-based reference model
module tb_pc_stack_unit;
  localparam int ADDR_W     = 10;
  localparam int DISP_W     = 8;
  localparam int DEPTH      = 8;
  localparam int RESET_ADDR = 0;
  localparam int MASK       = (1 << ADDR_W) - 1;
  localparam int SP_W       = $clog2(DEPTH) + 1;

  logic clk;
  logic reset;

  pc_stack_unit_if #(.ADDR_W(ADDR_W), .DISP_W(DISP_W), .DEPTH(DEPTH)) bus ();

  pc_stack_unit #(
    .ADDR_W(ADDR_W), .DISP_W(DISP_W), .DEPTH(DEPTH),
    .RESET_ADDR(ADDR_W'(RESET_ADDR))
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int m_pc = RESET_ADDR;
  int m_stack[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  function automatic int sext_disp(input logic [DISP_W-1:0] d);
    int v;
    v = int'(d);
    if (v >= (1 << (DISP_W - 1))) v = v - (1 << DISP_W);
    return v;
  endfunction

  task automatic model_step(input bit en, input int op, input bit cnd,
                            input int target, input logic [DISP_W-1:0] d, input bit clr);
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (en) begin
      case (op)
        0: m_pc = (m_pc + 1) & MASK;
        1: m_pc = target & MASK;
        2: m_pc = cnd ? ((m_pc + sext_disp(d)) & MASK) : ((m_pc + 1) & MASK);
        3: begin
          if (m_stack.size() == DEPTH) m_ovf = 1;
          else begin
            m_stack.push_back((m_pc + 1) & MASK);
            m_pc = target & MASK;
          end
        end
        4: begin
          if (m_stack.size() == 0) m_unf = 1;
          else m_pc = m_stack.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (bus.pc_out === ADDR_W'(m_pc)) else begin
      errors++;
      $error("FAIL %s pc_out observed %0h expected %0h", tag, bus.pc_out, m_pc);
    end
    checks++;
    assert (bus.sp === SP_W'(m_stack.size())) else begin
      errors++;
      $error("FAIL %s sp observed %0d expected %0d", tag, bus.sp, m_stack.size());
    end
    checks++;
    assert (bus.stack_empty === (m_stack.size() == 0)) else begin
      errors++;
      $error("FAIL %s stack_empty observed %b expected %b", tag, bus.stack_empty, m_stack.size() == 0);
    end
    checks++;
    assert (bus.stack_full === (m_stack.size() == DEPTH)) else begin
      errors++;
      $error("FAIL %s stack_full observed %b expected %b", tag, bus.stack_full, m_stack.size() == DEPTH);
    end
    checks++;
    assert (bus.overflow === m_ovf) else begin
      errors++;
      $error("FAIL %s overflow observed %b expected %b", tag, bus.overflow, m_ovf);
    end
    checks++;
    assert (bus.underflow === m_unf) else begin
      errors++;
      $error("FAIL %s underflow observed %b expected %b", tag, bus.underflow, m_unf);
    end
  endtask

  // Literal expectation, independent of the model.
  task automatic expect_pc(input string tag, input int exp_pc, input int exp_sp);
    checks++;
    assert (bus.pc_out === ADDR_W'(exp_pc)) else begin
      errors++;
      $error("FAIL %s pc_out observed %0h expected %0h", tag, bus.pc_out, exp_pc);
    end
    checks++;
    assert (bus.sp === SP_W'(exp_sp)) else begin
      errors++;
      $error("FAIL %s sp observed %0d expected %0d", tag, bus.sp, exp_sp);
    end
  endtask

  task automatic step(input string tag, input bit en, input int op, input bit cnd,
                      input int target, input int d, input bit clr);
    @(negedge clk);
    reset       = 1'b0;
    bus.pc_en   = en;
    bus.op      = 3'(op);
    bus.cond    = cnd;
    bus.pc_in   = ADDR_W'(target);
    bus.disp    = DISP_W'(d);
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    model_step(en, op, cnd, target, DISP_W'(d), clr);
    check_all(tag);
  endtask

  // Reset while presenting arbitrary other inputs; reset must override them.
  task automatic do_reset(input string tag, input bit en, input int op, input bit clr);
    @(negedge clk);
    reset       = 1'b1;
    bus.pc_en   = en;
    bus.op      = 3'(op);
    bus.cond    = 1'b1;
    bus.pc_in   = ADDR_W'(10'h2AA);
    bus.disp    = '0;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    m_pc = RESET_ADDR;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
    check_all(tag);
  endtask

  initial begin
    reset       = 1'b1;
    bus.pc_en   = 1'b0;
    bus.op      = 3'd0;
    bus.cond    = 1'b0;
    bus.pc_in   = '0;
    bus.disp    = '0;
    bus.clr_err = 1'b0;

    do_reset("reset", 1'b1, 1, 1'b0);
    expect_pc("reset_lit", 0, 0);

    // Three increments from reset.
    step("inc1", 1, 0, 0, 0, 0, 0); expect_pc("inc1_lit", 1, 0);
    step("inc2", 1, 0, 0, 0, 0, 0); expect_pc("inc2_lit", 2, 0);
    step("inc3", 1, 0, 0, 0, 0, 0); expect_pc("inc3_lit", 3, 0);

    // Wrap-around in both directions.
    step("load_3fe", 1, 1, 0, 10'h3FE, 0, 0);
    step("wrap_inc1", 1, 0, 0, 0, 0, 0); expect_pc("wrap_inc1_lit", 10'h3FF, 0);
    step("wrap_inc2", 1, 0, 0, 0, 0, 0); expect_pc("wrap_inc2_lit", 10'h000, 0);
    step("br_neg", 1, 2, 1, 0, 8'hFF, 0); expect_pc("br_neg_lit", 10'h3FF, 0);
    step("br_nt", 1, 2, 0, 0, 8'hFF, 0); expect_pc("br_nt_lit", 10'h000, 0);
    step("br_pos", 1, 2, 1, 0, 8'h7F, 0); expect_pc("br_pos_lit", 10'h07F, 0);

    // Nested call/return.
    step("load_010", 1, 1, 0, 10'h010, 0, 0);
    step("call1", 1, 3, 0, 10'h100, 0, 0); expect_pc("call1_lit", 10'h100, 1);
    step("call2", 1, 3, 0, 10'h200, 0, 0); expect_pc("call2_lit", 10'h200, 2);
    step("ret1", 1, 4, 0, 0, 0, 0); expect_pc("ret1_lit", 10'h101, 1);
    step("ret2", 1, 4, 0, 0, 0, 0); expect_pc("ret2_lit", 10'h011, 0);

    // Fill, overflow, set-beats-clear, clear.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 3, 0, 10'h040 + i, 0, 0);
    step("over", 1, 3, 0, 10'h3AA, 0, 0); expect_pc("over_lit", 10'h047, 8);
    step("over_clr_same", 1, 3, 0, 10'h3AA, 0, 1);
    step("clr_err", 0, 5, 0, 0, 0, 1);
    step("pop_after_full", 1, 4, 0, 0, 0, 0); expect_pc("pop_after_full_lit", 10'h047, 7);

    // Underflow and pc_en=0 hold.
    do_reset("reset2", 0, 0, 0);
    step("under", 1, 4, 0, 0, 0, 0); expect_pc("under_lit", 0, 0);
    step("hold_load", 0, 1, 0, 10'h055, 0, 0); expect_pc("hold_load_lit", 0, 0);
    step("hold_op", 1, 5, 0, 10'h055, 0, 0);
    step("reserved", 1, 6, 0, 10'h055, 0, 0);
    step("clr_under", 1, 0, 0, 0, 0, 1);

    // Reset with a non-empty stack discards it.
    step("pre_call1", 1, 3, 0, 10'h123, 0, 0);
    step("pre_call2", 1, 3, 0, 10'h321, 0, 0);
    do_reset("reset_mid", 1, 3, 0);
    expect_pc("reset_mid_lit", 0, 0);
    step("ret_after_reset", 1, 4, 0, 0, 0, 0);
    checks++;
    assert (bus.underflow === 1'b1) else begin
      errors++;
      $error("FAIL ret_after_reset_lit underflow observed %b expected 1", bus.underflow);
    end

    // Randomised mix, call/ret weighted so the stack reaches both ends.
    for (int n = 0; n < 600; n++) begin
      int r;
      int op;
      r = int'($urandom_range(0, 99));
      if (r < 25) op = 3;
      else if (r < 50) op = 4;
      else op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) do_reset("rand_reset", 1, op, 0);
      else step("rand", $urandom_range(0, 9) != 0, op, 1'($urandom),
                int'($urandom_range(0, MASK)), int'($urandom_range(0, 255)),
                $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
